// File: rtl/serial_add16_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit lookahead nibble per clock, LSB first, with a
// ready/valid request side and a ready/valid result side held stable under backpressure.
module serial_add16_ctrl #(
  parameter int unsigned N_NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*N_NIB-1:0] a_in,
  input  logic [4*N_NIB-1:0] b_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*N_NIB-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned W    = 4 * N_NIB;
  localparam int unsigned IdxW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_reg_q, carry_reg_d;
  logic [IdxW-1:0]   nib_idx_q, nib_idx_d;
  logic [4:0]        nib_res;

  // 4-bit carry-lookahead add; returns {carry_out, sum}.
  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic cin);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign nib_res = nib_add(a_q[4*nib_idx_q +: 4], b_q[4*nib_idx_q +: 4], carry_reg_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_reg_q <= 1'b0;
      nib_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_reg_q <= carry_reg_d;
      nib_idx_q   <= nib_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_reg_d = carry_reg_q;
    nib_idx_d   = nib_idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d         = a_in;
          b_d         = sub ? ~b_in : b_in;
          carry_reg_d = sub;
          nib_idx_d   = '0;
          state_d     = StRun;
        end
      end
      StRun: begin
        sum_d[4*nib_idx_q +: 4] = nib_res[3:0];
        carry_reg_d             = nib_res[4];
        // Hold the index on the last nibble instead of wrapping.
        if (nib_idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          nib_idx_d = nib_idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    sum       = sum_q;
    carry     = out_valid & carry_reg_q;
    overflow  = out_valid & (a_q[W-1] == b_q[W-1]) & (sum_q[W-1] != a_q[W-1]);
  end

endmodule

// File: doc/serial_add16_ctrl.md
SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 The block SHALL have parameter N_NIB, default 4, meaning number of 4-bit nibbles per operand (operand width W = 4*N_NIB).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port in_valid  input  1  requester presents an operation.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have port a_in  input  W  operand A.
REQ-007 The block SHALL have port b_in  input  W  operand B.
REQ-008 The block SHALL have port sub  input  1  1 = compute A-B, 0 = compute A+B.
REQ-009 The block SHALL have port out_valid  output  1  result is valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 The block SHALL have port sum  output  W  result.
REQ-012 The block SHALL have port carry  output  1  final carry-out (for sub: 1 = no borrow).
REQ-013 The block SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-014 The block SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-015 The block SHALL sequence one 4-bit prefix-adder nibble add per clock, LSB nibble first, with the carry registered between nibbles.
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; on in_valid=1 the block SHALL latch a_in, b_eff = sub ? ~b_in : b_in, carry_reg = sub, nib_idx = 0, and go to RUN.
REQ-018 In RUN, each cycle SHALL compute nibble[nib_idx] = A_nib + Beff_nib + carry_reg, write it to sum[4*nib_idx+3:4*nib_idx], load carry_reg with the nibble carry-out, and increment nib_idx.
REQ-019 The block SHALL leave RUN for DONE on the cycle that processes nib_idx = N_NIB-1; nib_idx SHALL NOT wrap inside RUN.
REQ-020 The latency SHALL be exactly N_NIB cycles: if accept occurs on edge T, out_valid SHALL be 1 after edge T+N_NIB.
REQ-021 In DONE, out_valid SHALL be 1; carry SHALL equal carry_reg; overflow SHALL equal (A[W-1]==Beff[W-1]) && (sum[W-1]!=A[W-1]).
REQ-022 While out_valid=1 and out_ready=0, sum, carry and overflow SHALL hold stable.
REQ-023 In DONE, out_ready=1 SHALL cause a return to IDLE on the next edge.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored in those states, including in the DONE->IDLE handshake cycle, so there is no same-cycle re-accept.
REQ-025 In RUN, changes on a_in, b_in and sub SHALL NOT affect the operation in flight.
REQ-026 The block SHALL have no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE and set sum=0, carry=0, overflow=0, out_valid=0, busy=0, nib_idx=0 and carry_reg=0.
REQ-028 in_ready SHALL be 1 from the first edge after rst_n returns to 1.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no partial result presented.

Verification
REQ-030 The bench SHALL cover add: a=0x1234, b=0x1111, sub=0 -> sum=0x2345, carry=0, overflow=0, out_valid exactly 4 cycles after accept.
REQ-031 The bench SHALL cover full ripple: 0xFFFF+0x0001 -> sum=0x0000, carry=1, overflow=0.
REQ-032 The bench SHALL cover subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0 (borrow), overflow=0.
REQ-033 The bench SHALL cover signed overflow: 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1.
REQ-034 The bench SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 and new operands -> sum and out_valid held, in_ready=0, no accept; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 The bench SHALL cover reset mid-RUN: rst_n=0 after 2 nibbles -> all outputs 0 next edge, IDLE; a following 0x0001+0x0001 -> 0x0002.
